// File: rtl/conv3x3_relu.sv
// conv3x3_relu: streaming 3x3 convolution with ReLU, shift and saturation.
// Accepts raster-order pixels, keeps two line buffers and a 3x3 window, and feeds a 3-stage MAC pipeline.
module conv3x3_relu #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int SHIFT      = 0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  w_load,
    input  logic [3:0]            w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int PW = 2*DATA_WIDTH + 1;
    localparam int AW = 2*DATA_WIDTH + 5;

    logic signed [DATA_WIDTH-1:0] w [9];
    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] win [9];
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic win_v, win_last, p_v, p_last, s_v, s_last;
    logic signed [PW-1:0] prod [9];
    logic signed [AW-1:0] acc, sum;
    logic [AW-1:0] t;

    always_comb begin
        acc = '0;
        for (int i = 0; i < 9; i++)
            acc = acc + {{(AW-PW){prod[i][PW-1]}}, prod[i]};
        t = sum >> SHIFT;
    end

    // Window index is row*3+col; column 2 holds the newest pixel of each row
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < 9; i++) begin
                w[i]    <= '0;
                win[i]  <= '0;
                prod[i] <= '0;
            end
            for (int i = 0; i < IMG_WIDTH-1; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            col        <= '0;
            row        <= '0;
            win_v      <= 1'b0;
            win_last   <= 1'b0;
            p_v        <= 1'b0;
            p_last     <= 1'b0;
            s_v        <= 1'b0;
            s_last     <= 1'b0;
            sum        <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            frame_done <= 1'b0;
        end else begin
            if (w_load && w_addr <= 4'd8)
                w[w_addr] <= w_data;
            win_v    <= valid_in && row >= RW'(2) && col >= CW'(2);
            win_last <= valid_in && row == RW'(IMG_HEIGHT-1) && col == CW'(IMG_WIDTH-1);
            if (valid_in) begin
                col <= (col == CW'(IMG_WIDTH-1)) ? '0 : col + 1'b1;
                if (col == CW'(IMG_WIDTH-1))
                    row <= (row == RW'(IMG_HEIGHT-1)) ? '0 : row + 1'b1;
                for (int i = IMG_WIDTH-2; i > 0; i--) begin
                    lb0[i] <= lb0[i-1];
                    lb1[i] <= lb1[i-1];
                end
                lb0[0] <= win[8];
                lb1[0] <= win[5];
                for (int r = 0; r < 3; r++) begin
                    win[3*r]   <= win[3*r+1];
                    win[3*r+1] <= win[3*r+2];
                end
                win[2] <= lb1[IMG_WIDTH-2];
                win[5] <= lb0[IMG_WIDTH-2];
                win[8] <= data_in;
            end
            for (int i = 0; i < 9; i++)
                prod[i] <= PW'($signed({1'b0, win[i]})) * PW'(w[i]);
            p_v        <= win_v;
            p_last     <= win_last;
            sum        <= acc;
            s_v        <= p_v;
            s_last     <= p_last;
            valid_out  <= s_v;
            frame_done <= s_v && s_last;
            if (s_v)
                data_out <= sum[AW-1] ? '0 : (|t[AW-1:DATA_WIDTH] ? '1 : t[DATA_WIDTH-1:0]);
        end
    end
endmodule

// File: tb/tb_conv3x3_relu.sv
// tb_conv3x3_relu: randomized check of conv3x3_relu (4x4 frames, SHIFT 0 and 3) against a frame-array model.
module tb_conv3x3_relu;
    localparam int W = 4;
    localparam int H = 4;

    typedef struct {int sum; bit last; int due;} exp_t;

    logic clk = 0;
    logic rst = 0;
    logic valid_in = 0, w_load = 0;
    logic [7:0] data_in = 0, w_data = 0;
    logic [3:0] w_addr = 0;
    logic valid_out, frame_done, valid_out_s3, frame_done_s3;
    logic [7:0] data_out, data_out_s3;

    int n_vec = 0, n_err = 0, cyc = 0, mpos = 0;
    int mw [9];
    int img [H][W];
    int pwin [9];
    bit pend = 0, plast = 0;
    int last0 = 0, last3 = 0;
    exp_t q [$];
    int got [$];
    int gotc [$];

    conv3x3_relu #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SHIFT(0)) u_dut (
        .Clk(clk), .Rst(rst), .valid_in(valid_in), .data_in(data_in), .w_load(w_load),
        .w_addr(w_addr), .w_data(w_data), .valid_out(valid_out), .data_out(data_out),
        .frame_done(frame_done));

    conv3x3_relu #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SHIFT(3)) u_dut_s3 (
        .Clk(clk), .Rst(rst), .valid_in(valid_in), .data_in(data_in), .w_load(w_load),
        .w_addr(w_addr), .w_data(w_data), .valid_out(valid_out_s3), .data_out(data_out_s3),
        .frame_done(frame_done_s3));

    always #5 clk = ~clk;

    task automatic chk(string tag, int obs, int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int sat(int s, int sh);
        if (s < 0) return 0;
        s = s >>> sh;
        return (s > 255) ? 255 : s;
    endfunction

    // One clock: drive inputs, then update the model exactly as the pixel/weight rules dictate
    task automatic step(bit v, int d, bit wl, int wa, int wd);
        bit ev;
        int s, r, c;
        exp_t e;
        valid_in = v;
        data_in  = d[7:0];
        w_load   = wl;
        w_addr   = wa[3:0];
        w_data   = wd[7:0];
        @(posedge clk);
        cyc++;
        if (pend) begin
            s = 0;
            for (int k = 0; k < 9; k++) s += pwin[k] * mw[k];
            q.push_back('{s, plast, cyc + 2});
            pend = 0;
        end
        if (wl && wa <= 8) mw[wa] = int'($signed(wd[7:0]));
        if (v) begin
            r = mpos / W;
            c = mpos % W;
            img[r][c] = d & 255;
            if (r >= 2 && c >= 2) begin
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        pwin[dr*3+dc] = img[r-2+dr][c-2+dc];
                pend  = 1;
                plast = (mpos == W*H - 1);
            end
            mpos = (mpos + 1) % (W*H);
        end
        #1;
        ev = q.size() > 0 && q[0].due == cyc;
        chk("valid_out", valid_out, ev);
        chk("valid_out_s3", valid_out_s3, ev);
        if (ev) begin
            e = q.pop_front();
            last0 = sat(e.sum, 0);
            last3 = sat(e.sum, 3);
            chk("frame_done", frame_done, e.last);
            chk("frame_done_s3", frame_done_s3, e.last);
        end
        chk("data_out", data_out, last0);
        chk("data_out_s3", data_out_s3, last3);
        if (valid_out) begin
            got.push_back(data_out);
            gotc.push_back(cyc);
        end
    endtask

    task automatic frame(int pv, int gap, int npix, int wr_at, int wa, int wd);
        int d;
        for (int k = 0; k < npix; k++) begin
            if (gap > 0) repeat ($urandom_range(1, gap)) step(0, $urandom_range(0, 255), 0, 0, 0);
            d = (pv == -1) ? int'($urandom_range(0, 255)) : (pv == 256) ? k : pv;
            step(1, d, k == wr_at, wa, wd);
        end
    endtask

    task automatic drain();
        repeat (5) step(0, 0, 0, 0, 0);
    endtask

    task automatic load_all(int v);
        for (int a = 0; a < 9; a++) step(0, 0, 1, a, v);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_valid"}, valid_out | valid_out_s3, 0);
        chk({tag, "_data"}, data_out | data_out_s3, 0);
        chk({tag, "_fd"}, frame_done | frame_done_s3, 0);
    endtask

    task automatic async_reset();
        #2 rst = 0;
        #1 check_zero("rst_async");
        q.delete();
        pend = 0;
        mpos = 0;
        last0 = 0;
        last3 = 0;
        for (int k = 0; k < 9; k++) mw[k] = 0;
        repeat (3) begin
            @(posedge clk);
            #1 check_zero("rst_hold");
        end
        rst = 1;
    endtask

    initial begin
        int c0;
        int exp_d [4] = '{5, 6, 9, 10};
        int exp_c [4] = '{14, 15, 18, 19};
        for (int k = 0; k < 9; k++) mw[k] = 0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        rst = 1;

        // identity kernel, pixels 0..15: outputs and their exact cycles
        step(0, 0, 1, 4, 1);
        got.delete();
        gotc.delete();
        c0 = cyc;
        frame(256, 0, 16, -1, 0, 0);
        drain();
        chk("id_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk("id_data", got[i], exp_d[i]);
            chk("id_latency", gotc[i] - c0, exp_c[i]);
        end

        // all-ones kernel, two back-to-back frames of 10s, then ReLU, saturation, shift
        load_all(1);
        frame(10, 0, 16, -1, 0, 0);
        frame(10, 0, 16, -1, 0, 0);
        drain();
        load_all(-1);
        frame(10, 0, 16, -1, 0, 0);
        drain();
        load_all(1);
        frame(255, 0, 16, -1, 0, 0);
        frame(8, 0, 16, -1, 0, 0);
        drain();

        // identity kernel with gaps in valid_in
        load_all(0);
        step(0, 0, 1, 4, 1);
        frame(256, 5, 16, -1, 0, 0);
        frame(-1, 5, 16, -1, 0, 0);
        drain();

        // weight write on the edge the first window enters the multiply stage; ignored address
        frame(256, 0, 16, 11, 0, 2);
        frame(256, 0, 16, 3, 12, 99);
        drain();

        // reset mid-frame after pixel 10, then a fresh frame with new weights
        frame(256, 0, 11, -1, 0, 0);
        async_reset();
        for (int a = 0; a < 9; a++) step(0, 0, 1, a, $urandom_range(0, 255));
        frame(-1, 0, 16, -1, 0, 0);
        drain();

        // random kernels, pixels, gaps and stray weight writes
        repeat (6) begin
            for (int a = 0; a < 9; a++) step(0, 0, 1, a, $urandom_range(0, 255));
            frame(-1, 2, 16, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
        end
        drain();
        chk("drain_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
